// File: rtl/mips_ctrl_pkg.sv
// Shared types and defaults for the MIPS program-load/run sequencer.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_RUN,
        ST_DONE
    } run_state_t;

    localparam logic CORE_RST_ASSERT = 1'b1;

    localparam int DEF_MAX_WORDS   = 256;
    localparam int DEF_CYC_W       = 16;
    localparam int DEF_MAX_CYCLES  = 65535;
    localparam int DEF_HALT_STABLE = 2;

endpackage

// File: rtl/mips_run_ctrl_if.sv
// Instruction-stream valid/ready channel from the host into the run controller.
interface mips_run_ctrl_if;

    logic        In_Valid;
    logic [31:0] In_Data;
    logic        In_Last;
    logic        In_Ready;

    modport master (output In_Valid, output In_Data, output In_Last, input In_Ready);
    modport slave  (input In_Valid, input In_Data, input In_Last, output In_Ready);

endinterface

// File: rtl/mips_run_ctrl_halt_detect.sv
// Halt detector: flags a PC that has stayed unchanged for HALT_STABLE consecutive compares.
module halt_detect
    import mips_ctrl_pkg::*;
#(
    parameter int HALT_STABLE = DEF_HALT_STABLE
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        en,
    input  logic [31:0] pc,
    output logic        halt
);

    localparam int SW = $clog2(HALT_STABLE + 1);

    logic [31:0]   prev_pc;
    logic          ref_vld;
    logic [SW-1:0] stable_cnt;
    logic [SW-1:0] stable_nxt;
    logic          same;

    // The first enabled cycle only captures the reference PC; no compare yet.
    always_comb begin
        same       = ref_vld && (pc == prev_pc);
        stable_nxt = same ? stable_cnt + SW'(1) : '0;
        halt       = en && same && (stable_nxt == SW'(HALT_STABLE));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prev_pc    <= '0;
            ref_vld    <= 1'b0;
            stable_cnt <= '0;
        end else if (en) begin
            prev_pc    <= pc;
            ref_vld    <= 1'b1;
            stable_cnt <= stable_nxt;
        end else begin
            ref_vld    <= 1'b0;
            stable_cnt <= '0;
        end
    end

endmodule

// File: rtl/mips_run_ctrl.sv
// Program-load and run sequencer: writes the core's instruction memory, runs it,
// and reports halt/timeout with the captured result.
//
// state    | meaning
// IDLE     | waiting for Start, core held in reset
// LOAD     | accepting instruction words, one WE pulse per beat
// DRAIN    | last WE pulse presented, core still in reset
// RUN      | core released, counting cycles, watching PC
// DONE     | status frozen until next Start
module mips_run_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MAX_WORDS   = DEF_MAX_WORDS,
    parameter int CYC_W       = DEF_CYC_W,
    parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
    parameter int HALT_STABLE = DEF_HALT_STABLE
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             Start,
    mips_run_ctrl_if.slave                   in_if,
    output logic                             Core_RST,
    output logic [31:0]                      W_Ins,
    output logic                             WE,
    input  logic [31:0]                      PC,
    input  logic [31:0]                      Result,
    output logic                             Busy,
    output logic                             Done,
    output logic                             Timeout,
    output logic [CYC_W-1:0]                 Cycles,
    output logic [31:0]                      Final_Result,
    output logic [$clog2(MAX_WORDS+1)-1:0]   Word_Cnt
);

    localparam int WC_W = $clog2(MAX_WORDS + 1);

    run_state_t       state, state_nxt;
    logic             beat;
    logic             start_go;
    logic             halt;
    logic             tmr_tc;
    logic [CYC_W-1:0] tmr;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_go  = 1'b0;
        beat      = (state == ST_LOAD) && in_if.In_Valid;
        tmr_tc    = (tmr == '0);
        case (state)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    start_go  = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (beat && (in_if.In_Last || (Word_Cnt == WC_W'(MAX_WORDS - 1))))
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: state_nxt = ST_RUN;
            ST_RUN: begin
                if (halt || tmr_tc)
                    state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign in_if.In_Ready = (state == ST_LOAD);
    assign Core_RST       = (state == ST_RUN) ? ~CORE_RST_ASSERT : CORE_RST_ASSERT;
    assign Busy           = (state == ST_LOAD) || (state == ST_RUN);

    halt_detect #(.HALT_STABLE(HALT_STABLE)) u_halt (
        .CLK  (CLK),
        .RST  (RST),
        .en   (state == ST_RUN),
        .pc   (PC),
        .halt (halt)
    );

    // Timeout runs as a down-counter loaded in DRAIN; terminal count marks the last RUN cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            W_Ins        <= '0;
            WE           <= 1'b0;
            Word_Cnt     <= '0;
            Done         <= 1'b0;
            Timeout      <= 1'b0;
            Cycles       <= '0;
            Final_Result <= '0;
            tmr          <= '0;
        end else begin
            WE <= beat;
            if (beat) begin
                W_Ins    <= in_if.In_Data;
                Word_Cnt <= Word_Cnt + WC_W'(1);
            end
            if (start_go) begin
                Done     <= 1'b0;
                Timeout  <= 1'b0;
                Cycles   <= '0;
                Word_Cnt <= '0;
            end
            if (state == ST_DRAIN)
                tmr <= CYC_W'(MAX_CYCLES - 1);
            if (state == ST_RUN) begin
                Cycles <= Cycles + CYC_W'(1);
                tmr    <= tmr - CYC_W'(1);
                if (halt || tmr_tc) begin
                    Done         <= 1'b1;
                    Timeout      <= ~halt;
                    Final_Result <= Result;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl with a write-port scoreboard.
module tb_mips_run_ctrl;

    localparam int MAXW = 256;
    localparam int CW   = 16;
    localparam int MAXC = 20;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic            Start = 1'b0;
    logic            Core_RST;
    logic [31:0]     W_Ins;
    logic            WE;
    logic [31:0]     PC = '0;
    logic [31:0]     Result = '0;
    logic            Busy, Done, Timeout;
    logic [CW-1:0]   Cycles;
    logic [31:0]     Final_Result;
    logic [8:0]      Word_Cnt;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] sb[$];

    mips_run_ctrl_if bus ();

    mips_run_ctrl #(.MAX_WORDS(MAXW), .CYC_W(CW), .MAX_CYCLES(MAXC), .HALT_STABLE(2)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .in_if(bus),
        .Core_RST(Core_RST), .W_Ins(W_Ins), .WE(WE), .PC(PC), .Result(Result),
        .Busy(Busy), .Done(Done), .Timeout(Timeout), .Cycles(Cycles),
        .Final_Result(Final_Result), .Word_Cnt(Word_Cnt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_core_rst"}, 32'(Core_RST), 1);
        chk({tag, "_in_ready"}, 32'(bus.In_Ready), 0);
        chk({tag, "_we"}, 32'(WE), 0);
        chk({tag, "_busy"}, 32'(Busy), 0);
        chk({tag, "_done"}, 32'(Done), 0);
        chk({tag, "_timeout"}, 32'(Timeout), 0);
        chk({tag, "_w_ins"}, W_Ins, 0);
        chk({tag, "_cycles"}, 32'(Cycles), 0);
        chk({tag, "_final"}, Final_Result, 0);
        chk({tag, "_word_cnt"}, 32'(Word_Cnt), 0);
    endtask

    // Drive one word for one edge; push it only when the bench expects it accepted.
    task automatic drive_word(input logic [31:0] d, input logic last, input logic accept);
        bus.In_Valid = 1'b1;
        bus.In_Data  = d;
        bus.In_Last  = last;
        if (accept) sb.push_back(d);
        step();
        bus.In_Valid = 1'b0;
        bus.In_Last  = 1'b0;
    endtask

    task automatic do_start();
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (RST && WE) begin
            if (sb.size() == 0) begin
                chk("we_unexpected", 32'(WE), 0);
            end else begin
                chk("we_data", W_Ins, sb.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] prog [3];
        logic [31:0] pcs  [5];
        int done_at;
        prog[0] = 32'h20080005; prog[1] = 32'h21080001; prog[2] = 32'h08000002;
        pcs[0] = 0; pcs[1] = 4; pcs[2] = 8; pcs[3] = 8; pcs[4] = 8;
        bus.In_Valid = 1'b0; bus.In_Data = '0; bus.In_Last = 1'b0;

        step(); step();
        chk_reset_vals("rst");
        RST = 1'b1;
        step();
        chk("idle_core_rst", 32'(Core_RST), 1);

        // Load three words, then halt after PC 0,4,8,8,8
        do_start();
        chk("load_in_ready", 32'(bus.In_Ready), 1);
        chk("load_busy", 32'(Busy), 1);
        for (int i = 0; i < 3; i++) drive_word(prog[i], i == 2, 1'b1);
        chk("drain_in_ready", 32'(bus.In_Ready), 0);
        chk("drain_core_rst", 32'(Core_RST), 1);
        chk("load3_word_cnt", 32'(Word_Cnt), 3);
        step();
        chk("run_core_rst", 32'(Core_RST), 0);
        chk("run_busy", 32'(Busy), 1);
        for (int r = 1; r <= 5; r++) begin
            PC = pcs[r-1];
            Result = 32'hA000 + 32'(r);
            step();
            if (r == 4) chk("halt_not_early", 32'(Done), 0);
        end
        chk("halt_done", 32'(Done), 1);
        chk("halt_timeout", 32'(Timeout), 0);
        chk("halt_cycles", 32'(Cycles), 5);
        chk("halt_final", Final_Result, 32'hA005);
        chk("halt_core_rst", 32'(Core_RST), 1);
        step(); step();
        chk("done_cycles_frozen", 32'(Cycles), 5);
        chk("done_held", 32'(Done), 1);

        // Start from DONE clears flags; then timeout with PC always changing
        do_start();
        chk("restart_done", 32'(Done), 0);
        chk("restart_cycles", 32'(Cycles), 0);
        chk("restart_word_cnt", 32'(Word_Cnt), 0);
        drive_word(32'h12345678, 1'b1, 1'b1);
        step();
        done_at = 0;
        for (int r = 1; r <= 40 && done_at == 0; r++) begin
            PC = 32'(4 * r);
            Result = 32'hB000 + 32'(r);
            step();
            if (Done) done_at = r;
        end
        chk("to_done_cycle", 32'(done_at), MAXC);
        chk("to_timeout", 32'(Timeout), 1);
        chk("to_cycles", 32'(Cycles), MAXC);
        chk("to_final", Final_Result, 32'hB000 + MAXC);

        // Valid with gaps; constant PC halts on third RUN cycle
        do_start();
        drive_word(32'hD0000001, 1'b0, 1'b1);
        step();
        drive_word(32'hD0000002, 1'b0, 1'b1);
        step(); step();
        drive_word(32'hD0000003, 1'b1, 1'b1);
        chk("gap_word_cnt", 32'(Word_Cnt), 3);
        PC = 32'h40;
        step();
        for (int r = 1; r <= 3; r++) begin
            Result = 32'hE000 + 32'(r);
            step();
        end
        chk("gap_done", 32'(Done), 1);
        chk("gap_timeout", 32'(Timeout), 0);
        chk("gap_cycles", 32'(Cycles), 3);
        chk("gap_final", Final_Result, 32'hE003);

        // Full 256-word load without In_Last; 257th word must not be written
        do_start();
        for (int i = 0; i < MAXW; i++) begin
            chk("full_in_ready", 32'(bus.In_Ready), 1);
            drive_word(32'hC0000000 + 32'(i), 1'b0, 1'b1);
        end
        chk("full_ready_drop", 32'(bus.In_Ready), 0);
        drive_word(32'hDEADBEEF, 1'b0, 1'b0);
        chk("full_word_cnt", 32'(Word_Cnt), MAXW);
        chk("full_run", 32'(Core_RST), 0);

        // Reset mid-RUN at Cycles=7
        for (int r = 1; r <= 7; r++) begin
            PC = 32'h1000 + 32'(4 * r);
            step();
        end
        chk("midrun_cycles", 32'(Cycles), 7);
        chk("midrun_done", 32'(Done), 0);
        RST = 1'b0;
        #1;
        chk_reset_vals("abort");
        step();
        RST = 1'b1;
        step();
        chk("post_abort_core_rst", 32'(Core_RST), 1);
        chk("post_abort_busy", 32'(Busy), 0);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
